ram_fifo: RTL and testbench
===========================

RAM_FIFO -- requirements
Module: ram_fifo

Interface
- REQ-001 SHALL have parameter: WIDTH, 8, data word width in bits.
- REQ-002 SHALL have parameter: DEPTH, 16, total word capacity; power of two, >= 4.
- REQ-003 SHALL have parameter: ADDRESS_WIDTH, clog2(DEPTH), RAM address width.
- REQ-004 SHALL have port: clock  input  1  single clock; all state on rising edge.
- REQ-005 SHALL have port: resetn  input  1  reset, asynchronous and active-low.
- REQ-006 SHALL have port: write_valid  input  1  producer presents write_data.
- REQ-007 SHALL have port: write_data  input  WIDTH  word to enqueue.
- REQ-008 SHALL have port: write_ready  output  1  block can accept a word this cycle.
- REQ-009 SHALL have port: read_valid  output  1  read_data holds the oldest word.
- REQ-010 SHALL have port: read_data  output  WIDTH  oldest word.
- REQ-011 SHALL have port: read_ready  input  1  consumer takes read_data this cycle.
- REQ-012 SHALL have port: level  output  ADDRESS_WIDTH+1  stored-word count; present only with RAM_FIFO_LEVEL_EN.

Function
- REQ-013 SHALL count a write as accepted in a cycle with write_valid=1 and write_ready=1, and a read as accepted in a cycle with read_valid=1 and read_ready=1.
- REQ-014 SHALL keep an occupancy count of every stored word: RAM, in-flight RAM read and output buffer; +1 per accepted write, -1 per accepted read, unchanged if both occur.
- REQ-015 SHALL drive write_ready = (occupancy < DEPTH), combinationally from registered state only; write_ready SHALL NOT depend on read_ready.
- REQ-016 SHALL store accepted writes through RAM port 0 at write_pointer, then increment write_pointer modulo DEPTH.
- REQ-017 SHALL issue a RAM read on port 1 at read_pointer when the RAM holds an unread word committed on an earlier edge and (buffered + in-flight) < 2; read_pointer then increments modulo DEPTH.
- REQ-018 SHALL never read an address written on the same edge; a word written on edge E is readable no earlier than edge E+1.
- REQ-019 SHALL capture RAM read data, one cycle after the read is issued, into a 2-entry output buffer; the head entry drives read_data.
- REQ-020 SHALL assert read_valid whenever the output buffer is non-empty; read_data SHALL hold stable while read_valid=1 and read_ready=0.
- REQ-021 SHALL give first-word latency from empty: write accepted in cycle 0, read_valid=1 in cycle 3.
- REQ-022 SHALL sustain one write and one read per cycle indefinitely once the output buffer is primed.
- REQ-023 SHALL ignore write_valid while full, with no state change, and SHALL ignore read_ready while read_valid=0.
- REQ-024 SHALL preserve order and data across pointer wrap-around at DEPTH-1 -> 0.

Reset
- REQ-025 SHALL, on resetn low at any time including mid-transfer, immediately set: pointers 0, occupancy 0, buffer empty, in-flight flag 0, read_valid 0, write_ready 1, level 0.
- REQ-026 SHALL leave RAM contents uninitialised; read_data is don't-care while read_valid=0.

Configuration
- REQ-027 SHALL, with RAM_FIFO_LEVEL_EN defined, expose level equal to occupancy, registered and updated on the same edge as occupancy.
- REQ-028 SHALL, without RAM_FIFO_LEVEL_EN, omit the level port; all other behaviour is identical.

Structure
- REQ-029 SHALL place the 2-entry output buffer depth constant and the pointer/occupancy width helpers in shared package ram_fifo_pkg.
- REQ-030 SHALL instantiate true_dual_port_ram as its one sub-module, with REGISTERED_READ=1, port 0 write-only and port 1 read-only.

Verification
- REQ-031 SHALL cover: reset, then write 0xA5 in cycle 0 with read_ready=1 -> read_valid=1 and read_data=0xA5 in cycle 3, then read_valid=0.
- REQ-032 SHALL cover: DEPTH=16, 16 writes with read_ready=0 -> write_ready=0 after the 16th, level=16; a 17th write is ignored; 16 reads return 0..15 in order.
- REQ-033 SHALL cover: full, then write_valid=1 and read_ready=1 in one cycle -> only the read is accepted; level 16->15, write_ready=1 next cycle.
- REQ-034 SHALL cover: continuous stream of 40 incrementing words, both valid and ready held high -> 40 words out in order, no bubbles after priming, pointers wrap twice.
- REQ-035 SHALL cover: random read_ready stalls -> read_data stable during stalls and no loss or duplication over 1000 words.
- REQ-036 SHALL cover: resetn low while 5 words are stored and a RAM read is in flight -> read_valid=0, write_ready=1, level=0 at once; the next written word is the first read out.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// Shared constants and width helpers for the RAM-backed FIFO.
package ram_fifo_pkg;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned BUF_IDX_W = $clog2(BUF_DEPTH);
  localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned occ_width(input int unsigned address_width);
    return address_width + 1;
  endfunction

endpackage

// File: rtl/true_dual_port_ram.sv
// Dual-port RAM: port 0 write-only, port 1 read-only, optional registered read.
module true_dual_port_ram #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned ADDRESS_WIDTH   = 4,
  parameter int unsigned REGISTERED_READ = 1
) (
  input  logic                     clock,
  input  logic                     write_enable_0,
  input  logic [ADDRESS_WIDTH-1:0] address_0,
  input  logic [WIDTH-1:0]         write_data_0,
  input  logic                     read_enable_1,
  input  logic [ADDRESS_WIDTH-1:0] address_1,
  output logic [WIDTH-1:0]         read_data_1
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_enable_0) mem[address_0] <= write_data_0;
  end

  generate
    if (REGISTERED_READ != 0) begin : g_reg_read
      always_ff @(posedge clock) begin
        if (read_enable_1) read_data_1 <= mem[address_1];
      end
    end else begin : g_comb_read
      assign read_data_1 = mem[address_1];
    end
  endgenerate

endmodule

// File: rtl/ram_fifo.sv
// RAM-backed FIFO with a 2-entry output buffer hiding the registered RAM read.
// Optional level output enabled by defining RAM_FIFO_LEVEL_EN.
module ram_fifo
  import ram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDRESS_WIDTH = ptr_width(DEPTH)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     write_valid,
  input  logic [WIDTH-1:0]         write_data,
  output logic                     write_ready,
  output logic                     read_valid,
  output logic [WIDTH-1:0]         read_data,
  input  logic                     read_ready
`ifdef RAM_FIFO_LEVEL_EN
  ,
  output logic [ADDRESS_WIDTH:0]   level
`endif
);

  localparam int unsigned OCC_W = occ_width(ADDRESS_WIDTH);

  logic [ADDRESS_WIDTH-1:0] write_pointer;
  logic [ADDRESS_WIDTH-1:0] read_pointer;
  logic [OCC_W-1:0]         occupancy;
  logic                     inflight;
  logic [BUF_CNT_W-1:0]     buf_count;
  logic [BUF_IDX_W-1:0]     buf_head;
  logic [WIDTH-1:0]         buf_data [BUF_DEPTH];
  logic [WIDTH-1:0]         ram_read_data;

  logic                     write_accept_c;
  logic                     read_accept_c;
  logic                     ram_read_c;
  logic [OCC_W-1:0]         ram_count_c;
  logic [BUF_CNT_W-1:0]     buf_after_pop_c;
  logic [BUF_IDX_W-1:0]     buf_tail_c;

  assign write_ready = occupancy < OCC_W'(DEPTH);
  assign read_valid  = buf_count != '0;
  assign read_data   = buf_data[buf_head];

`ifdef RAM_FIFO_LEVEL_EN
  assign level = occupancy;
`endif

  // Read issue counts the slot freed by this cycle's pop so streaming never bubbles.
  always_comb begin
    write_accept_c  = write_valid && write_ready;
    read_accept_c   = read_valid && read_ready;
    ram_count_c     = occupancy - OCC_W'(buf_count) - OCC_W'(inflight);
    buf_after_pop_c = buf_count - BUF_CNT_W'(read_accept_c);
    buf_tail_c      = buf_head + BUF_IDX_W'(buf_count);
    ram_read_c      = (ram_count_c != '0) &&
                      ((buf_after_pop_c + BUF_CNT_W'(inflight)) < BUF_CNT_W'(BUF_DEPTH));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      occupancy     <= '0;
      inflight      <= 1'b0;
      buf_count     <= '0;
      buf_head      <= '0;
    end else begin
      if (write_accept_c) write_pointer <= write_pointer + ADDRESS_WIDTH'(1);
      if (ram_read_c)     read_pointer  <= read_pointer + ADDRESS_WIDTH'(1);
      inflight  <= ram_read_c;
      buf_count <= buf_after_pop_c + BUF_CNT_W'(inflight);
      if (read_accept_c) buf_head <= buf_head + BUF_IDX_W'(1);
      case ({write_accept_c, read_accept_c})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // When full, the tail aliases the head slot being popped on the same edge.
  always_ff @(posedge clock) begin
    if (inflight) buf_data[buf_tail_c] <= ram_read_data;
  end

  true_dual_port_ram #(
    .WIDTH           (WIDTH),
    .DEPTH           (DEPTH),
    .ADDRESS_WIDTH   (ADDRESS_WIDTH),
    .REGISTERED_READ (1)
  ) u_ram (
    .clock          (clock),
    .write_enable_0 (write_accept_c),
    .address_0      (write_pointer),
    .write_data_0   (write_data),
    .read_enable_1  (ram_read_c),
    .address_1      (read_pointer),
    .read_data_1    (ram_read_data)
  );

endmodule

// File: tb/tb_ram_fifo.sv
// Self-checking bench for ram_fifo: directed steps with a scoreboard queue.
module tb_ram_fifo;

  logic       clock;
  logic       resetn;
  logic       write_valid;
  logic [7:0] write_data;
  logic       write_ready;
  logic       read_valid;
  logic [7:0] read_data;
  logic       read_ready;
`ifdef RAM_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  ram_fifo #(.WIDTH(8), .DEPTH(16), .ADDRESS_WIDTH(4)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .write_valid (write_valid),
    .write_data  (write_data),
    .write_ready (write_ready),
    .read_valid  (read_valid),
    .read_data   (read_data),
    .read_ready  (read_ready)
`ifdef RAM_FIFO_LEVEL_EN
    ,
    .level       (level)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive inputs, score handshakes, advance one cycle.
  task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr);
    logic [7:0] exp;
    write_valid = wv;
    write_data  = wd;
    read_ready  = rr;
    if (wv && write_ready) sb.push_back(wd);
    if (rr && read_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_word", 32'(read_data), 32'hFFFF_FFFF);
      end else begin
        exp = sb.pop_front();
        check("read_data", 32'(read_data), 32'(exp));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      cycle(1'b0, 8'h00, 1'b1);
      n++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    check({tag, "_empty_after"}, 32'(read_valid), 32'd0);
  endtask

  int         written;
  int         bubbles;
  int         n;
  logic       seen_valid;
  logic       prev_stall;
  logic [7:0] held;
  logic       wv_r;
  logic       rr_r;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    write_valid = 1'b0;
    write_data  = 8'h00;
    read_ready  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_read_valid", 32'(read_valid), 32'd0);
    check("reset_write_ready", 32'(write_ready), 32'd1);
`ifdef RAM_FIFO_LEVEL_EN
    check("reset_level", 32'(level), 32'd0);
`endif
    resetn = 1'b1;

    // First-word latency: write in cycle 0, visible in cycle 3.
    check("lat_write_ready", 32'(write_ready), 32'd1);
    cycle(1'b1, 8'hA5, 1'b1);
    check("lat_c1_valid", 32'(read_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    check("lat_c2_valid", 32'(read_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    check("lat_c3_valid", 32'(read_valid), 32'd1);
    check("lat_c3_data", 32'(read_data), 32'hA5);
    cycle(1'b0, 8'h00, 1'b1);
    check("lat_c4_valid", 32'(read_valid), 32'd0);
    check("lat_sb_empty", 32'(sb.size()), 32'd0);

    // Fill to 16, 17th write ignored, then drain in order.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    check("full_write_ready", 32'(write_ready), 32'd0);
    check("full_accepted", 32'(sb.size()), 32'd16);
`ifdef RAM_FIFO_LEVEL_EN
    check("full_level", 32'(level), 32'd16);
`endif
    cycle(1'b1, 8'hEE, 1'b0);
    check("full_ignore_ready", 32'(write_ready), 32'd0);
`ifdef RAM_FIFO_LEVEL_EN
    check("full_ignore_level", 32'(level), 32'd16);
`endif
    drain("fill16");

    // Full with simultaneous write and read: only the read is taken.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    check("full2_write_ready", 32'(write_ready), 32'd0);
    cycle(1'b1, 8'h77, 1'b1);
    check("full2_ready_after_read", 32'(write_ready), 32'd1);
    check("full2_sb_size", 32'(sb.size()), 32'd15);
`ifdef RAM_FIFO_LEVEL_EN
    check("full2_level", 32'(level), 32'd15);
`endif
    drain("full2");

    // Continuous stream of 40 words; no bubbles once primed.
    bubbles    = 0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (read_valid) seen_valid = 1'b1;
      else if (seen_valid && sb.size() > 0) bubbles++;
      cycle(1'b1, 8'(8'h40 + i), 1'b1);
    end
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      if (read_valid) seen_valid = 1'b1;
      else if (seen_valid) bubbles++;
      cycle(1'b0, 8'h00, 1'b1);
      n++;
    end
    check("stream_bubbles", 32'(bubbles), 32'd0);
    check("stream_drained", 32'(sb.size()), 32'd0);
    check("stream_empty_after", 32'(read_valid), 32'd0);

    // Random producer and consumer stalls over 1000 words.
    written    = 0;
    prev_stall = 1'b0;
    held       = 8'h00;
    n          = 0;
    while ((written < 1000 || sb.size() > 0) && n < 20000) begin
      if (prev_stall) begin
        check("stall_valid", 32'(read_valid), 32'd1);
        check("stall_data", 32'(read_data), 32'(held));
      end
      wv_r       = (written < 1000) && ($urandom_range(0, 3) != 0);
      rr_r       = ($urandom_range(0, 2) != 0);
      prev_stall = read_valid && !rr_r;
      held       = read_data;
      if (wv_r && write_ready) begin
        cycle(1'b1, 8'(written), rr_r);
        written++;
      end else begin
        cycle(wv_r, 8'(written), rr_r);
      end
      n++;
    end
    check("random_written", 32'(written), 32'd1000);
    check("random_drained", 32'(sb.size()), 32'd0);

    // Reset with 5 words stored and a RAM read in flight.
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("mid_sb_size", 32'(sb.size()), 32'd5);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_reset_read_valid", 32'(read_valid), 32'd0);
    check("mid_reset_write_ready", 32'(write_ready), 32'd1);
`ifdef RAM_FIFO_LEVEL_EN
    check("mid_reset_level", 32'(level), 32'd0);
`endif
    sb.delete();
    write_valid = 1'b0;
    read_ready  = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    cycle(1'b1, 8'h3C, 1'b1);
    n = 0;
    while (!read_valid && n < 10) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    check("post_reset_valid", 32'(read_valid), 32'd1);
    check("post_reset_first", 32'(read_data), 32'h3C);
    drain("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
